// File: rtl/frame_buffer_dp_pkg.sv
// Shared definitions for the frame buffer: controller states and the default
// display geometry that sets the storage depth.
package frame_buffer_dp_pkg;

  typedef enum logic [0:0] {
    FB_IDLE  = 1'b0,
    FB_CLEAR = 1'b1
  } fb_state_e;

  localparam int H_RES    = 640;
  localparam int V_RES    = 480;
  localparam int FB_DEPTH = H_RES * V_RES;

  // Address bits needed to index a given number of locations (at least 1).
  function automatic int fb_addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/frame_buffer_dp_ram.sv
// Plain simple dual-port RAM: one write port, one registered read port.
// The array has no reset, so contents survive a controller reset. A read and
// a write of the same location in one cycle return the old contents.
module fb_ram_sdp #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 307200,
  parameter int AW     = 19
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write and registered read share one edge; nonblocking update gives read-first.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/frame_buffer_dp.sv
// Frame buffer with a write port, an independent read port and a clear
// sweep that fills every location with CLEAR_VAL, one location per cycle.
//
//   state    | meaning
//   FB_IDLE  | write port open, waiting for clear_req
//   FB_CLEAR | sweeping 0..DEPTH-1 with CLEAR_VAL, write port blocked
module frame_buffer_dp
  import frame_buffer_dp_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                DEPTH     = FB_DEPTH,
  parameter int                ADDR_W    = 19,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic              clear_done,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              addr_err
);

  localparam int                RAM_AW    = fb_addr_bits(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  fb_state_e         state;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_in_range;
  logic              rd_in_range;
  logic              clr_start;
  logic              clr_last;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_re;
  logic [DATA_W-1:0] ram_q;
  logic              rd_oor;
  logic              rd_fresh;

  assign wr_in_range = {1'b0, wr_addr} < DEPTH_L;
  assign rd_in_range = {1'b0, rd_addr} < DEPTH_L;
  assign clr_start   = (state == FB_IDLE) && clear_req;
  assign clr_last    = (state == FB_CLEAR) && (clr_addr == LAST_ADDR);
  assign clear_busy  = (state == FB_CLEAR);
  assign wr_ready    = (state == FB_IDLE);

  // Clear sequencer: start on request in IDLE, step the sweep address, pulse done at the end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= FB_IDLE;
      clr_addr   <= '0;
      clear_done <= 1'b0;
    end else begin
      clear_done <= 1'b0;
      case (state)
        FB_IDLE: begin
          if (clear_req) begin
            state    <= FB_CLEAR;
            clr_addr <= '0;
          end
        end
        FB_CLEAR: begin
          if (clr_last) begin
            state      <= FB_IDLE;
            clear_done <= 1'b1;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
      endcase
    end
  end

  // RAM write source: the sweep owns the port during CLEAR, otherwise in-range user writes.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = wr_addr[RAM_AW-1:0];
    ram_wdata = wr_data;
    if (state == FB_CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_addr[RAM_AW-1:0];
      ram_wdata = CLEAR_VAL;
    end else begin
      ram_we = wr_en && wr_in_range;
    end
  end

  assign ram_re = rd_en && rd_in_range;

  fb_ram_sdp #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (RAM_AW)
  ) u_ram (
    .clk    (clk),
    .we     (ram_we),
    .waddr  (ram_waddr),
    .wdata  (ram_wdata),
    .re     (ram_re),
    .raddr  (rd_addr[RAM_AW-1:0]),
    .rdata  (ram_q)
  );

  // Sticky range error; a new error in the clear-start cycle still wins so it is not lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_err <= 1'b0;
    end else begin
      if (clr_start) begin
        addr_err <= 1'b0;
      end
      if ((wr_en && wr_ready && !wr_in_range) || (rd_en && !rd_in_range)) begin
        addr_err <= 1'b1;
      end
    end
  end

  // Read-side tags: rd_fresh forces zero until the first read, rd_oor substitutes CLEAR_VAL.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_oor   <= 1'b0;
      rd_fresh <= 1'b1;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_oor   <= !rd_in_range;
        rd_fresh <= 1'b0;
      end
    end
  end

  // RAM output and tags only change on an accepted read, so rd_data holds between reads.
  assign rd_data = rd_fresh ? '0 : (rd_oor ? CLEAR_VAL : ram_q);

endmodule

// File: tb/tb_frame_buffer_dp.sv
// Directed bench for frame_buffer_dp with a small geometry (16 locations).
// Read expectations are queued when a read is issued and checked when
// rd_valid comes back one cycle later.
module tb_frame_buffer_dp;

  localparam int          DATA_W = 8;
  localparam int          DEPTH  = 16;
  localparam int          ADDR_W = 5;
  localparam logic [7:0]  CV     = 8'hAA;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              clear_req = 1'b0;
  logic              clear_busy;
  logic              clear_done;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_ready;
  logic              rd_en = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              addr_err;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  frame_buffer_dp #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .CLEAR_VAL (CV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .clear_done (clear_done),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .addr_err   (addr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs sampled 1ns after the edge, read results drained from the queue.
  task automatic step();
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      check("rd_valid", {31'd0, rd_valid}, 32'd1);
      check("rd_data", {24'd0, rd_data}, {24'd0, exp_q.pop_front()});
    end else begin
      check("rd_valid_low", {31'd0, rd_valid}, 32'd0);
    end
  endtask

  task automatic write_px(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic read_px(input logic [ADDR_W-1:0] a, input logic [7:0] e);
    rd_en = 1'b1; rd_addr = a;
    exp_q.push_back(e);
    step();
    rd_en = 1'b0;
  endtask

  initial begin
    // Reset state
    step();
    step();
    reset = 1'b0;
    #1;
    check("rst_busy", {31'd0, clear_busy}, 32'd0);
    check("rst_done", {31'd0, clear_done}, 32'd0);
    check("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
    check("rst_rd_data", {24'd0, rd_data}, 32'd0);
    check("rst_addr_err", {31'd0, addr_err}, 32'd0);

    // Basic write then read
    write_px(5'd3, 8'h5A);
    read_px(5'd3, 8'h5A);
    step();
    check("rd_hold", {24'd0, rd_data}, 32'h5A);

    // Clear sweep: write in the start cycle, blocked write and re-request mid-sweep
    clear_req = 1'b1; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 8'h33;
    step();
    clear_req = 1'b0; wr_en = 1'b0;
    check("busy_c1", {31'd0, clear_busy}, 32'd1);
    check("wr_ready_c1", {31'd0, wr_ready}, 32'd0);
    for (int c = 2; c <= 16; c++) begin
      if (c == 4) begin
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 8'h55;
        check("wr_ready_clr", {31'd0, wr_ready}, 32'd0);
      end
      if (c == 9) clear_req = 1'b1;
      step();
      wr_en = 1'b0; clear_req = 1'b0;
      check($sformatf("busy_c%0d", c), {31'd0, clear_busy}, 32'd1);
      check($sformatf("done_c%0d", c), {31'd0, clear_done}, 32'd0);
    end
    step();
    check("busy_c17", {31'd0, clear_busy}, 32'd0);
    check("done_c17", {31'd0, clear_done}, 32'd1);
    check("wr_ready_c17", {31'd0, wr_ready}, 32'd1);
    step();
    check("done_c18", {31'd0, clear_done}, 32'd0);
    for (int i = 0; i < DEPTH; i++) read_px(ADDR_W'(i), CV);

    // Same-cycle write and read of one address returns old data
    write_px(5'd7, 8'h22);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 8'h11;
    read_px(5'd7, 8'h22);
    wr_en = 1'b0;
    read_px(5'd7, 8'h11);

    // Out-of-range accesses (addr 20 aliases addr 4 in the low bits)
    write_px(5'd4, 8'h44);
    check("err_before", {31'd0, addr_err}, 32'd0);
    write_px(5'd20, 8'h77);
    check("err_wr_oor", {31'd0, addr_err}, 32'd1);
    read_px(5'd20, CV);
    read_px(5'd4, 8'h44);
    check("err_sticky", {31'd0, addr_err}, 32'd1);

    // Reset during a sweep keeps partially cleared contents
    for (int i = 0; i < DEPTH; i++) write_px(ADDR_W'(i), 8'(i * 3 + 1));
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    check("err_cleared", {31'd0, addr_err}, 32'd0);
    check("busy_r1", {31'd0, clear_busy}, 32'd1);
    repeat (8) step();
    check("busy_r9", {31'd0, clear_busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("abort_busy", {31'd0, clear_busy}, 32'd0);
    check("abort_done", {31'd0, clear_done}, 32'd0);
    check("abort_wr_ready", {31'd0, wr_ready}, 32'd1);
    step();
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      check("no_done_after_abort", {31'd0, clear_done}, 32'd0);
    end
    check("abort_rd_data", {24'd0, rd_data}, 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      if (i < 8) read_px(ADDR_W'(i), CV);
      else read_px(ADDR_W'(i), 8'(i * 3 + 1));
    end
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
